// File: rtl/uart_input_word_buffer_if.sv
// Byte-in / word-out bundle between the UART receiver, the word buffer and the writeback stage.
// Master drives received bytes and consume; slave returns the packed head word and status.
interface uart_input_word_buffer_if #(
    parameter int DEPTH_LOG2 = 3
);
    // rx_valid is a single-cycle strobe with no back-pressure: a byte is taken on
    // every cycle it is high. consume pops one head word per cycle while high, and
    // is ignored when input_ready is low. input_data is valid while input_ready is high.
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  consume;
    logic                  overflow_clear;
    logic                  input_ready;
    logic [31:0]           input_data;
    logic [DEPTH_LOG2:0]   word_count;
    logic [1:0]            partial_bytes;
    logic                  overflow;

    modport master (
        output rx_valid, rx_data, consume, overflow_clear,
        input  input_ready, input_data, word_count, partial_bytes, overflow
    );

    modport slave (
        input  rx_valid, rx_data, consume, overflow_clear,
        output input_ready, input_data, word_count, partial_bytes, overflow
    );
endinterface

// File: rtl/uart_input_word_buffer.sv
// Packs UART bytes big-endian into 32-bit words and queues them in a FWFT FIFO.
// Define UART_INPUT_BYTE_MODE_EN to push every byte as its own zero-extended word.
module uart_input_word_buffer #(
    parameter int DEPTH_LOG2 = 3
) (
    input logic                    clk,
    input logic                    reset,
    uart_input_word_buffer_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    // State encoding doubles as the partial_bytes debug output.
    typedef enum logic [1:0] {
        BYTE0 = 2'd0,
        BYTE1 = 2'd1,
        BYTE2 = 2'd2,
        BYTE3 = 2'd3
    } asm_state_t;

    asm_state_t            state_q, state_d;
    logic [31:0]           asm_q, asm_d;
    logic [31:0]           word_in;
    logic                  word_done;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] head_q, tail_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  overflow_q;

    logic                  empty, full, pop, push, drop;

    always_comb begin
        state_d   = state_q;
        asm_d     = asm_q;
        word_done = 1'b0;
        word_in   = '0;
`ifdef UART_INPUT_BYTE_MODE_EN
        state_d   = BYTE0;
        asm_d     = '0;
        word_done = bus.rx_valid;
        word_in   = {24'b0, bus.rx_data};
`else
        if (bus.rx_valid) begin
            unique case (state_q)
                BYTE0: begin
                    asm_d[31:24] = bus.rx_data;
                    state_d      = BYTE1;
                end
                BYTE1: begin
                    asm_d[23:16] = bus.rx_data;
                    state_d      = BYTE2;
                end
                BYTE2: begin
                    asm_d[15:8] = bus.rx_data;
                    state_d     = BYTE3;
                end
                BYTE3: begin
                    word_done = 1'b1;
                    word_in   = {asm_q[31:8], bus.rx_data};
                    asm_d     = '0;
                    state_d   = BYTE0;
                end
                default: state_d = BYTE0;
            endcase
        end
`endif
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_COUNT);
    assign pop   = bus.consume && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push  = word_done && (!full || pop);
    assign drop  = word_done && full && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BYTE0;
            asm_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            asm_q   <= asm_d;
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop)
                overflow_q <= 1'b1;
            else if (bus.overflow_clear)
                overflow_q <= 1'b0;
        end
    end

    // Storage needs no reset: reads are masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!reset && push) mem[tail_q] <= word_in;
    end

    assign bus.input_ready = !empty;
    assign bus.input_data  = empty ? 32'h0 : mem[head_q];
    assign bus.word_count  = count_q;
    assign bus.overflow    = overflow_q;
`ifdef UART_INPUT_BYTE_MODE_EN
    assign bus.partial_bytes = 2'b00;
`else
    assign bus.partial_bytes = state_q;
`endif
endmodule
